// File: rtl/vga_pkg.sv
// vga_pkg: port addresses, default CGA palette and sequencer states for vga_dac
package vga_pkg;
    localparam logic [15:0] DEF_PORT_BASE = 16'h03C7;
    localparam logic [15:0] DEF_PORT_STAT = 16'h03DA;
    localparam logic [15:0][11:0] CGA = {
        12'hFFF, 12'hFF5, 12'hF5F, 12'hF55, 12'h5FF, 12'h5F5, 12'h55F, 12'h555,
        12'hAAA, 12'hA50, 12'hA0A, 12'hA00, 12'h0AA, 12'h0A0, 12'h00A, 12'h000
    };
    typedef enum logic [1:0] {INIT, IDLE, PREF} state_t;
    function automatic logic [11:0] default_color(input logic [7:0] idx);
        return idx < 8'd16 ? CGA[idx[3:0]] : 12'h000;
    endfunction
endpackage

// File: rtl/palette_ram.sv
// palette_ram: 256x12 palette with one write port, a free-running video read and an enabled CPU prefetch read
module palette_ram (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [7:0]  wa,
    input  logic [11:0] wd,
    input  logic [7:0]  va,
    output logic [11:0] vq,
    input  logic        re,
    input  logic [7:0]  ra,
    output logic [11:0] rq
);
    logic [11:0] mem [256];
    always_ff @(posedge clock) begin
        if (we) mem[wa] <= wd;
        vq <= mem[va];
    end
    // prefetch output doubles as the CPU readback latch, so it holds between prefetches
    always_ff @(posedge clock) begin
        if (reset) rq <= '0;
        else if (re) rq <= mem[ra];
    end
endmodule

// File: rtl/vga_dac.sv
// vga_dac: palette DAC with PC-style 3C7h/3C8h/3C9h/3DAh ports and a default-palette reset sweep
module vga_dac
    import vga_pkg::*;
#(
    parameter int          INIT_LAST = 255,
    parameter logic [15:0] PORT_BASE = DEF_PORT_BASE,
    parameter logic [15:0] PORT_STAT = DEF_PORT_STAT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] port_a,
    input  logic [7:0]  port_i,
    input  logic        port_w,
    input  logic        port_r,
    output logic [7:0]  port_o,
    input  logic [7:0]  dac_a,
    output logic [11:0] dac_q,
    input  logic        vretrace,
    output logic        busy
);
    state_t      state;
    logic [8:0]  ic;
    logic [7:0]  widx, ridx, wa;
    logic [1:0]  wph, rph;
    logic [3:0]  r, g, c;
    logic        mode, vr;
    logic [11:0] rlat, wd;
    logic        hit_ri, hit_wi, hit_dat, hit_st, live, commit, we;

    always_comb begin
        hit_ri  = port_a == PORT_BASE;
        hit_wi  = port_a == PORT_BASE + 16'd1;
        hit_dat = port_a == PORT_BASE + 16'd2;
        hit_st  = port_a == PORT_STAT;
        live    = state != INIT;
        commit  = !reset && live && port_w && hit_dat && wph == 2'd2;
        we      = state == INIT || commit;
        wa      = live ? widx : ic[7:0];
        wd      = live ? {r, g, port_i[5:2]} : default_color(ic[7:0]);
        c       = rph == 2'd0 ? rlat[11:8] : rph == 2'd1 ? rlat[7:4] : rlat[3:0];
    end

    palette_ram u_ram (
        .clock(clock),
        .reset(reset),
        .we(we),
        .wa(wa),
        .wd(wd),
        .va(dac_a),
        .vq(dac_q),
        .re(state == PREF),
        .ra(ridx),
        .rq(rlat)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= INIT;
            ic     <= '0;
            busy   <= 1'b1;
            widx   <= '0;
            ridx   <= '0;
            wph    <= '0;
            rph    <= '0;
            r      <= '0;
            g      <= '0;
            mode   <= 1'b0;
            vr     <= 1'b0;
            port_o <= 8'h00;
        end else begin
            vr <= vr | vretrace;
            if (state == INIT) begin
                ic <= ic + 9'd1;
                if (ic == 9'(INIT_LAST)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                if (port_r) port_o <= 8'hFF;
            end else begin
                if (state == PREF) state <= IDLE;
                if (port_w) begin
                    if (hit_ri) begin
                        ridx  <= port_i;
                        rph   <= '0;
                        mode  <= 1'b0;
                        state <= PREF;
                    end
                    if (hit_wi) begin
                        widx <= port_i;
                        wph  <= '0;
                        mode <= 1'b1;
                    end
                    if (hit_dat) begin
                        if (wph == 2'd0) begin
                            r   <= port_i[5:2];
                            wph <= 2'd1;
                        end else if (wph == 2'd1) begin
                            g   <= port_i[5:2];
                            wph <= 2'd2;
                        end else begin
                            widx <= widx + 8'd1;
                            wph  <= '0;
                            if (widx == ridx) state <= PREF;
                        end
                    end
                    if (port_r) port_o <= 8'hFF;
                end else if (port_r) begin
                    port_o <= hit_dat ? {2'b00, c, c[3:2]} :
                              hit_ri  ? {6'b0, {2{mode}}} :
                              hit_wi  ? widx :
                              hit_st  ? {4'b0, vr, 2'b0, vr} : 8'hFF;
                    if (hit_st) vr <= vretrace;
                    if (hit_dat) begin
                        rph <= rph == 2'd2 ? 2'd0 : rph + 2'd1;
                        if (rph == 2'd2) begin
                            ridx  <= ridx + 8'd1;
                            state <= PREF;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_dac.sv
// tb_vga_dac: scoreboard bench; stimulus queues expected port/video responses, monitors pop and compare
module tb_vga_dac;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] port_a = '0;
    logic [7:0]  port_i = '0;
    logic        port_w = 1'b0;
    logic        port_r = 1'b0;
    logic [7:0]  port_o;
    logic [7:0]  dac_a = '0;
    logic [11:0] dac_q;
    logic        vretrace = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [11:0] port_exp[$], vid_exp[$];
    string       port_name[$], vid_name[$];
    logic        rd_d = 1'b0, vid_d = 1'b0, vid_req = 1'b0;

    vga_dac dut (
        .clock(clock),
        .reset(reset),
        .port_a(port_a),
        .port_i(port_i),
        .port_w(port_w),
        .port_r(port_r),
        .port_o(port_o),
        .dac_a(dac_a),
        .dac_q(dac_q),
        .vretrace(vretrace),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string n, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(posedge clock) begin
        rd_d  <= port_r;
        vid_d <= vid_req;
    end

    always @(negedge clock) begin
        if (rd_d) begin
            if (port_exp.size() == 0) check("port_unexpected", {4'h0, port_o}, 12'hEEE);
            else check(port_name.pop_front(), {4'h0, port_o}, port_exp.pop_front());
        end
        if (vid_d) begin
            if (vid_exp.size() == 0) check("vid_unexpected", dac_q, 12'hEEE);
            else check(vid_name.pop_front(), dac_q, vid_exp.pop_front());
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pw(input logic [15:0] a, input logic [7:0] d);
        port_a = a; port_i = d; port_w = 1'b1;
        tick();
        port_w = 1'b0;
        tick();
    endtask

    task automatic pr(input logic [15:0] a, input logic [7:0] e, input string n);
        port_exp.push_back({4'h0, e}); port_name.push_back(n);
        port_a = a; port_r = 1'b1;
        tick();
        port_r = 1'b0;
        tick();
    endtask

    task automatic vid(input logic [7:0] a, input logic [11:0] e, input string n);
        vid_exp.push_back(e); vid_name.push_back(n);
        dac_a = a; vid_req = 1'b1;
        tick();
        vid_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string n);
        int k = 0;
        while (busy && k < 400) begin tick(); k++; end
        check(n, 12'(busy), 12'h0);
    endtask

    initial begin
        int n;
        tick();
        do_reset();
        check("rst_port_o", {4'h0, port_o}, 12'h000);
        check("rst_busy", 12'(busy), 12'h001);
        n = 0;
        while (busy && n < 400) begin tick(); n++; end
        check("busy_fall_cycle", 12'(n), 12'd256);

        vid(8'd4, 12'hA00, "def_4");
        vid(8'd14, 12'hFF5, "def_14");
        vid(8'd200, 12'h000, "def_200");
        vid(8'd15, 12'hFFF, "def_15");
        vid(8'd9, 12'h55F, "def_9");
        tick();
        pr(16'h03C7, 8'h00, "mode_rst");
        pr(16'h03C8, 8'h00, "widx_rst");
        pr(16'h03DA, 8'h00, "vr_rst");

        pw(16'h03C8, 8'h20);
        pr(16'h03C7, 8'h03, "mode_write");
        pw(16'h03C9, 8'h3F);
        pw(16'h03C9, 8'h00);
        pw(16'h03C9, 8'h15);
        vid(8'd32, 12'hF05, "triplet_32");
        tick();
        pr(16'h03C8, 8'h21, "widx_inc");

        pw(16'h03C8, 8'hFF);
        pw(16'h03C9, 8'h3C); pw(16'h03C9, 8'h00); pw(16'h03C9, 8'h00);
        pw(16'h03C9, 8'h00); pw(16'h03C9, 8'hFC); pw(16'h03C9, 8'h00);
        vid(8'd255, 12'hF00, "wrap_255");
        vid(8'd0, 12'h0F0, "wrap_0");
        tick();
        pr(16'h03C8, 8'h01, "wrap_widx");

        pw(16'h03C7, 8'h04);
        pr(16'h03C9, 8'h2A, "rb4_r");
        pr(16'h03C9, 8'h00, "rb4_g");
        pr(16'h03C9, 8'h00, "rb4_b");
        pr(16'h03C9, 8'h2A, "rb5_r");
        pr(16'h03C9, 8'h00, "rb5_g");
        pr(16'h03C9, 8'h2A, "rb5_b");
        pr(16'h03C7, 8'h00, "mode_read");

        pw(16'h03C7, 8'h07);
        pw(16'h03C8, 8'h07);
        pw(16'h03C9, 8'h3C); pw(16'h03C9, 8'h3C); pw(16'h03C9, 8'h00);
        pr(16'h03C9, 8'h3F, "coh_r");
        pr(16'h03C9, 8'h3F, "coh_g");
        pr(16'h03C9, 8'h00, "coh_b");

        port_exp.push_back(12'h0FF); port_name.push_back("wr_rd_same");
        port_a = 16'h03C8; port_i = 8'h40; port_w = 1'b1; port_r = 1'b1;
        tick();
        port_w = 1'b0; port_r = 1'b0;
        tick();
        pr(16'h03C8, 8'h40, "wr_rd_write_done");
        pr(16'h0123, 8'hFF, "unmapped");

        vretrace = 1'b1; tick(); vretrace = 1'b0; tick();
        pr(16'h03DA, 8'h09, "vr_set");
        pr(16'h03DA, 8'h00, "vr_clear");
        port_exp.push_back(12'h000); port_name.push_back("vr_coincide_rd");
        port_a = 16'h03DA; port_r = 1'b1; vretrace = 1'b1;
        tick();
        port_r = 1'b0; vretrace = 1'b0;
        tick();
        pr(16'h03DA, 8'h09, "vr_kept");

        pw(16'h03C8, 8'h00);
        pw(16'h03C9, 8'h3F);
        pw(16'h03C9, 8'h3F);
        do_reset();
        check("midrst_busy", 12'(busy), 12'h001);
        check("midrst_port_o", {4'h0, port_o}, 12'h000);
        pr(16'h03C8, 8'hFF, "init_read");
        pw(16'h03C8, 8'h09);
        wait_idle("midrst_idle");
        vid(8'd0, 12'h000, "midrst_e0");
        vid(8'd7, 12'hAAA, "midrst_e7");
        tick();
        pr(16'h03C8, 8'h00, "init_write_dropped");
        pw(16'h03C9, 8'h04); pw(16'h03C9, 8'h08); pw(16'h03C9, 8'h0C);
        vid(8'd0, 12'h123, "midrst_wph0");
        tick();
        pr(16'h03C8, 8'h01, "midrst_widx");

        repeat (3) tick();
        check("queues_drained", 12'(port_exp.size() + vid_exp.size()), 12'h000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
